// File: rtl/cpu_core_mc_if.sv
// Bus bundle for cpu_core_mc: instruction-memory read port and the OUT stream.
//   imem_addr  core -> mem   instruction address (= pc)
//   imem_data  mem  -> core  16-bit instruction word, combinational
//   out_data   core -> sink  OUT payload
//   out_valid  core -> sink  payload valid
//   out_ready  sink -> core  transfer accepted when valid & ready at a clk edge
interface cpu_core_mc_if #(
  parameter int DW  = 8,
  parameter int PCW = 4
);
  logic [PCW-1:0] imem_addr;
  logic [15:0]    imem_data;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output imem_addr,
    input  imem_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: parametrised multi-cycle CPU core (FETCH/EXEC/OUTW/HALT).
// 16-bit ISA: op=[15:12], rd=[11:8], rs=[7:4], imm=[7:0]; register index is
// the low RAW bits of the rd/rs field.
// Ports:
//   clk, rst            clock (rising), asynchronous active-high reset
//   bus (master)        imem read port + OUT valid/ready stream
//   halted              core stopped by HLT (only reset leaves)
//   flag_z, flag_c      zero and carry/borrow flags
//   dbg_sel, dbg_data   combinational register-file peek, no side effects

// One register-file entry; instantiated once per register.
module cpu_core_mc_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= wd;
  end
endmodule

module cpu_core_mc #(
  parameter int DW  = 8,
  parameter int RAW = 2,
  parameter int PCW = 4
) (
  input  logic           clk,
  input  logic           rst,
  cpu_core_mc_if.master  bus,
  output logic           halted,
  output logic           flag_z,
  output logic           flag_c,
  input  logic [RAW-1:0] dbg_sel,
  output logic [DW-1:0]  dbg_data
);
  localparam int NREG = 1 << RAW;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_OUTW, S_HALT} state_t;

  typedef struct packed {
    logic [3:0]     op;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rs;
    logic [7:0]     imm;
  } dec_t;

  state_t state, state_nx;
  logic [PCW-1:0] pc, pc_nx, pc_inc, jmp_tgt;
  logic [15:0]    ir;
  dec_t           dec;
  logic           z, c, z_nx, c_nx;
  logic           ov, ov_nx;
  logic [DW-1:0]  od, od_nx;
  logic           ir_ld;

  // register file, one slice per entry
  logic [NREG-1:0][DW-1:0] rf;
  logic [NREG-1:0]         rf_we_vec;
  logic                    rf_we;
  logic [DW-1:0]           rf_wd;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rf
      assign rf_we_vec[gi] = rf_we && (dec.rd == RAW'(gi));
      cpu_core_mc_reg #(.DW(DW)) u_reg (
        .clk (clk),
        .rst (rst),
        .we  (rf_we_vec[gi]),
        .wd  (rf_wd),
        .q   (rf[gi])
      );
    end
  endgenerate

  // decode from the latched instruction
  always_comb begin
    dec.op  = ir[15:12];
    dec.rd  = ir[8 +: RAW];
    dec.rs  = ir[4 +: RAW];
    dec.imm = ir[7:0];
  end

  // rd/rs fields wider than RAW only contribute their low bits
  logic unused_ir;
  assign unused_ir = ^ir;

  logic [DW-1:0] rdv, rsv, imm_ext, res;
  logic [DW:0]   sum, diff;
  logic          flag_upd;

  assign rdv     = rf[dec.rd];
  assign rsv     = rf[dec.rs];
  // zero-extend or truncate imm to DW
  assign imm_ext = DW'(dec.imm);
  assign jmp_tgt = PCW'(dec.imm);
  assign sum     = {1'b0, rdv} + {1'b0, rsv};
  // borrow lands in the top bit of the unsigned difference
  assign diff    = {1'b0, rdv} - {1'b0, rsv};
  assign pc_inc  = pc + PCW'(1);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // next-state / datapath control
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_ld    = 1'b0;
    rf_we    = 1'b0;
    rf_wd    = '0;
    res      = '0;
    flag_upd = 1'b0;
    z_nx     = z;
    c_nx     = c;
    ov_nx    = ov;
    od_nx    = od;
    case (state)
      S_FETCH: begin
        ir_ld    = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        pc_nx    = pc_inc;
        case (dec.op)
          4'h1: begin rf_we = 1'b1; rf_wd = imm_ext; end
          4'h2: begin res = sum[DW-1:0];  c_nx = sum[DW];  flag_upd = 1'b1; end
          4'h3: begin res = diff[DW-1:0]; c_nx = diff[DW]; flag_upd = 1'b1; end
          4'h4: begin res = rdv & rsv; flag_upd = 1'b1; end
          4'h5: begin res = rdv | rsv; flag_upd = 1'b1; end
          4'h6: begin res = rdv ^ rsv; flag_upd = 1'b1; end
          4'h7: begin rf_we = 1'b1; rf_wd = rsv; end
          4'h8: pc_nx = jmp_tgt;
          4'h9: if (z)  pc_nx = jmp_tgt;
          4'hA: if (!z) pc_nx = jmp_tgt;
          4'hB: begin
            // pc advances only once the payload is accepted
            od_nx    = rsv;
            ov_nx    = 1'b1;
            pc_nx    = pc;
            state_nx = S_OUTW;
          end
          4'hF: begin
            pc_nx    = pc;
            state_nx = S_HALT;
          end
          default: ;
        endcase
        if (flag_upd) begin
          rf_we = 1'b1;
          rf_wd = res;
          z_nx  = (res == '0);
        end
      end
      S_OUTW: begin
        if (ov && bus.out_ready) begin
          ov_nx    = 1'b0;
          pc_nx    = pc_inc;
          state_nx = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_nx = S_FETCH;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
      z  <= 1'b0;
      c  <= 1'b0;
      ov <= 1'b0;
      od <= '0;
    end else begin
      pc <= pc_nx;
      if (ir_ld) ir <= bus.imem_data;
      z  <= z_nx;
      c  <= c_nx;
      ov <= ov_nx;
      od <= od_nx;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.out_data  = od;
  assign bus.out_valid = ov;
  assign halted        = (state == S_HALT);
  assign flag_z        = z;
  assign flag_c        = c;
  assign dbg_data      = rf[dbg_sel];
endmodule
